edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//  Per-channel rising-edge detection on N_CH asynchronous level inputs, with sticky pending events.
//  Round-robin arbitration of pending events onto one valid/ready event port carrying the channel id.
//  Sits between raw status lines and the single event consumer (interrupt/log sequencer).
// PARAMETERS
//  N_CH         4   number of level channels (2..16)
//  SYNC_STAGES  2   synchronizer flops per channel (>=1)
//  ID_W      (derived, package constant) $clog2(N_CH), width of evt_id
// PORTS
//  clk        in   1      single clock, all flops rising-edge
//  rst        in   1      reset, asynchronous, active-high
//  level      in   N_CH   raw level inputs, asynchronous to clk
//  evt_valid  out  1      event presented
//  evt_ready  in   1      consumer accepts; transfer when evt_valid & evt_ready
//  evt_id     out  ID_W   channel index of presented event
//  pending_o  out  N_CH   pending bits (events detected, not yet presented)
//  ovf        out  N_CH   sticky per-channel overflow (see CONFIGURATION)
//  ovf_clr    in   1      1-cycle pulse clears all ovf bits
// BEHAVIOUR
//  Reset (rst=1, async): sync chain=0, prev=0, pending=0, ovf=0, evt_valid=0, evt_id=0,
//    rr pointer last=N_CH-1 (ch0 highest priority first), FSM=IDLE.
//  Since prev resets to 0, a level held high through reset yields exactly one event after release.
//  Edge detect: rise[i] = sync[i] & ~prev[i]. prev <= sync every cycle. Falling edges are ignored.
//  Pending: rise[i] sets pending[i]. The bit clears in the cycle the FSM loads channel i into evt_id.
//    If rise[i] coincides with the load of i, pending[i] stays 1 (new event wins).
//  Latency: level high sampled at clk edge k -> pending at edge k+SYNC_STAGES ->
//    evt_valid at edge k+SYNC_STAGES+1 (IDLE, no contention). Default: 4 edges incl. k.
//  Pulses shorter than one clk period may be missed. Each level high after a low yields one event.
//  FSM:
//   IDLE:    |pending -> load winner, evt_valid<=1, last<=winner, -> PRESENT. Else stay.
//   PRESENT: evt_valid=1; evt_id stable while !evt_ready.
//            evt_ready & |pending -> load next winner same cycle (back-to-back), stay.
//            evt_ready & ~|pending -> evt_valid<=0, -> IDLE.
//  Round-robin: winner = first pending index scanning last+1 .. N_CH-1, 0 .. last (wrap).
//  Loaded channel excluded from next scan only via its cleared pending bit. No starvation:
//    any pending channel is presented within N_CH transfers.
//  evt_ready while evt_valid=0 is ignored.
//  Reset mid-transfer: event lost; all state returns to reset values immediately.
// CONFIGURATION
//  Macro EDGE_ARB_OVF_EN:
//   defined:   ovf[i] set when rise[i] & pending[i] (second edge before the first was presented).
//              Sticky until ovf_clr. If set and clear coincide, set wins.
//   undefined: ovf tied to 0, ovf_clr ignored. Port list unchanged.
// STRUCTURE
//  Package edge_arb_pkg holds:
//   - ID_W computation function (clog2).
//   - FSM state encoding: IDLE=1'b0, PRESENT=1'b1.
//   - Reset constants for the rr pointer.
//  Sub-module edge_sync_cell, instanced per channel:
//   - SYNC_STAGES synchronizer plus prev flop.
//   - Outputs rise.
//  Top level holds pending/ovf vectors, the rr arbiter function and the FSM.
// TESTING
//  1 Reset release, level=4'b0001 held high through reset, evt_ready=1 ->
//    one event id=0 at edge 4 after release, then evt_valid=0.
//  2 level 4'b0000->4'b1011 same cycle, evt_ready=1 -> ids 0,1,3 on consecutive cycles, then evt_valid=0.
//  3 evt_ready=0 for 5 cycles with ch2 presented -> evt_valid=1, evt_id=2 stable.
//    Ready high -> next pending presented next cycle.
//  4 All 4 channels re-rise every 8 cycles, evt_ready=1 -> grant order 0,1,2,3,0,... with no channel skipped.
//  5 EDGE_ARB_OVF_EN, evt_ready=0, ch1 rises twice -> ovf=4'b0010.
//    ovf_clr pulse -> 0. Without macro -> ovf stays 0.
//  6 rst asserted while evt_valid=1 mid-burst -> evt_valid and pending=0 asynchronously.
//    No event after release with levels low.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// Shared constants for edge_event_arbiter: id width helper, FSM encoding and
// round-robin pointer reset value.
package edge_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_t;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Pointer starts at the top channel so the first scan begins at channel 0.
  function automatic int rr_last_reset(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/edge_sync_cell.sv
// One channel of level synchronizer plus previous-value flop; emits a
// single-cycle rise strobe on each synchronized low-to-high transition.
module edge_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= level;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector with round-robin presentation on a valid/ready port.
// Optional sticky per-channel overflow flags are built when EDGE_ARB_OVF_EN is defined.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int  N_CH        = 4,
  parameter int  SYNC_STAGES = 2,
  localparam int ID_W        = id_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] pending_o,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  // Handshake: an event transfers on a clock edge where evt_valid & evt_ready;
  // evt_id is held while evt_valid & ~evt_ready, and evt_ready alone is ignored.

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] pending_q;
  logic [N_CH-1:0] load_mask;
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] winner;
  logic            load_en;
  arb_state_t      state;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_sync_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0] w;
    logic            found;
    int              idx;
    w     = last;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last) + k) % N_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        w     = ID_W'(idx);
      end
    end
    return w;
  endfunction

  always_comb begin
    winner    = rr_pick(pending_q, last_q);
    load_en   = (|pending_q) && ((state == IDLE) || evt_ready);
    load_mask = '0;
    if (load_en) load_mask[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      last_q    <= ID_W'(rr_last_reset(N_CH));
    end else begin
      case (state)
        IDLE: begin
          if (load_en) begin
            state     <= PRESENT;
            evt_valid <= 1'b1;
            evt_id    <= winner;
            last_q    <= winner;
          end
        end
        PRESENT: begin
          if (evt_ready) begin
            if (load_en) begin
              evt_id <= winner;
              last_q <= winner;
            end else begin
              evt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // A rise arriving in the same cycle its channel is loaded re-arms the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~load_mask) | rise;
    end
  end

  assign pending_o = pending_q;

`ifdef EDGE_ARB_OVF_EN
  logic [N_CH-1:0] ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~{N_CH{ovf_clr}}) | (rise & pending_q);
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus randomized traffic
// against a behavioural event model; EDGE_ARB_OVF_EN selects ovf expectations.
`timescale 1ns/1ps
module tb_edge_event_arbiter;

  localparam int N_CH        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int ID_W        = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] level;
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [N_CH-1:0] pending_o;
  logic [N_CH-1:0] ovf;
  logic            ovf_clr;

  int n_checks = 0;
  int n_pass   = 0;

  edge_event_arbiter #(
    .N_CH       (N_CH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .level    (level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .pending_o(pending_o),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [N_CH-1:0] hist[SYNC_STAGES+2];
  bit              m_pend[N_CH];
  bit              m_ovf[N_CH];
  bit              m_valid;
  int              m_id;
  int              m_last;
  logic [ID_W-1:0] exp_q[$];
  int              dut_grants[$];
  int              grant_cyc[$];
  int              cyc = 0;
  bit              d_valid = 1'b0;
  int              d_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < SYNC_STAGES + 2; i++) hist[i] = '0;
    for (int i = 0; i < N_CH; i++) begin
      m_pend[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
    m_valid = 1'b0;
    m_id    = 0;
    m_last  = N_CH - 1;
    exp_q.delete();
  endfunction

  // Level seen at the edge detector is the input sampled SYNC_STAGES edges ago.
  function automatic void model_step();
    logic [N_CH-1:0] r;
    bit              any;
    int              w;
    for (int i = SYNC_STAGES + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = level;
    r = hist[SYNC_STAGES] & ~hist[SYNC_STAGES+1];
    if (m_valid && evt_ready) exp_q.push_back(ID_W'(m_id));
    for (int i = 0; i < N_CH; i++) begin
      if (ovf_clr) m_ovf[i] = 1'b0;
      if (r[i] && m_pend[i]) m_ovf[i] = 1'b1;
    end
    any = 1'b0;
    for (int i = 0; i < N_CH; i++) if (m_pend[i]) any = 1'b1;
    if (any && (!m_valid || evt_ready)) begin
      w = -1;
      for (int k = 1; k <= N_CH; k++) begin
        int idx = (m_last + k) % N_CH;
        if (w < 0 && m_pend[idx]) w = idx;
      end
      m_id      = w;
      m_last    = w;
      m_valid   = 1'b1;
      m_pend[w] = 1'b0;
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N_CH; i++) if (r[i]) m_pend[i] = 1'b1;
  endfunction

  function automatic logic [N_CH-1:0] pend_vec();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_ovf();
    logic [N_CH-1:0] v;
    v = '0;
`ifdef EDGE_ARB_OVF_EN
    for (int i = 0; i < N_CH; i++) v[i] = m_ovf[i];
`endif
    return v;
  endfunction

  // Model advance and DUT transfer scoreboard, once per rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      model_reset();
      d_valid = 1'b0;
    end else begin
      model_step();
      if (d_valid && evt_ready) begin
        dut_grants.push_back(d_id);
        grant_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("grant_unexpected", 32'(d_id), 32'hffff_ffff);
        else check("grant_id", 32'(d_id), 32'(exp_q.pop_front()));
      end
    end
  end

  // Per-cycle compare against the model, 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) check("evt_id", 32'(evt_id), 32'(m_id));
        check("pending", 32'(pending_o), 32'(pend_vec()));
        check("ovf", 32'(ovf), 32'(exp_ovf()));
      end
      d_valid = evt_valid;
      d_id    = int'(evt_id);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N_CH-1:0] lv, input logic rdy);
    @(negedge clk);
    level     = lv;
    evt_ready = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    level   = '0;
    ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!evt_valid && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(evt_valid), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_CH-1:0] ovf_exp;
    bit              seen;

    // 1: level high through reset gives exactly one event, valid at 4th edge.
    rst       = 1'b1;
    level     = 4'b0001;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_reset_valid", 32'(evt_valid), 32'd0);
    check("t1_reset_pending", 32'(pending_o), 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("t1_valid_e%0d", e), 32'(evt_valid), (e == 4) ? 32'd1 : 32'd0);
      if (e == 4) check("t1_id", 32'(evt_id), 32'd0);
    end

    // 2: simultaneous rises on 0,1,3 drain on consecutive cycles.
    do_reset();
    dut_grants.delete();
    grant_cyc.delete();
    drive(4'b1011, 1'b1);
    repeat (10) tick();
    check("t2_count", 32'(dut_grants.size()), 32'd3);
    if (dut_grants.size() >= 3) begin
      check("t2_g0", 32'(dut_grants[0]), 32'd0);
      check("t2_g1", 32'(dut_grants[1]), 32'd1);
      check("t2_g2", 32'(dut_grants[2]), 32'd3);
      check("t2_b2b_a", 32'(grant_cyc[1] - grant_cyc[0]), 32'd1);
      check("t2_b2b_b", 32'(grant_cyc[2] - grant_cyc[1]), 32'd1);
    end
    check("t2_idle", 32'(evt_valid), 32'd0);

    // 3: stalled consumer holds ch2; release shows ch3 next cycle.
    do_reset();
    drive(4'b0100, 1'b0);
    wait_valid(20, "t3_present");
    drive(4'b1100, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t3_hold_valid", 32'(evt_valid), 32'd1);
      check("t3_hold_id", 32'(evt_id), 32'd2);
    end
    drive(4'b1100, 1'b1);
    tick();
    check("t3_next_valid", 32'(evt_valid), 32'd1);
    check("t3_next_id", 32'(evt_id), 32'd3);
    drive(4'b1100, 1'b1);
    tick();
    check("t3_drained", 32'(evt_valid), 32'd0);

    // 4: all channels re-rise every 8 cycles; strict 0,1,2,3 rotation.
    do_reset();
    dut_grants.delete();
    for (int c = 0; c < 24; c++) drive(((c % 8) < 4) ? 4'b1111 : 4'b0000, 1'b1);
    repeat (6) drive(4'b0000, 1'b1);
    check("t4_count", 32'(dut_grants.size()), 32'd12);
    for (int i = 0; i < dut_grants.size() && i < 12; i++)
      check($sformatf("t4_g%0d", i), 32'(dut_grants[i]), 32'(i % 4));

    // 5: ch1 rises twice while ch0 blocks the port.
    do_reset();
    repeat (4) drive(4'b0001, 1'b0);
    repeat (3) drive(4'b0011, 1'b0);
    repeat (3) drive(4'b0001, 1'b0);
    repeat (3) drive(4'b0011, 1'b0);
    repeat (4) drive(4'b0001, 1'b0);
`ifdef EDGE_ARB_OVF_EN
    ovf_exp = 4'b0010;
`else
    ovf_exp = 4'b0000;
`endif
    tick();
    check("t5_ovf_set", 32'(ovf), 32'(ovf_exp));
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    tick();
    check("t5_ovf_clr", 32'(ovf), 32'd0);

    // Randomized traffic, checked every cycle by the compare process.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) level = N_CH'($urandom_range(0, (1 << N_CH) - 1));
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    ovf_clr = 1'b0;

    // 6: asynchronous reset in the middle of a burst.
    do_reset();
    drive(4'b1111, 1'b1);
    wait_valid(20, "t6_burst");
    #2;
    rst   = 1'b1;
    level = '0;
    #1;
    check("t6_async_valid", 32'(evt_valid), 32'd0);
    check("t6_async_pending", 32'(pending_o), 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (evt_valid) seen = 1'b1;
    end
    check("t6_no_event", 32'(seen), 32'd0);

    repeat (8) drive(4'b0000, 1'b1);
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
